// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between instruction fetch
//   (IF) and the MEM stage (DM). DM has fixed priority over IF because the
//   MEM-stage instruction is older. The memory side is a registered req/ack
//   handshake. Each requester gets registered read data and a one-cycle done
//   pulse. A memory access that waits MAX_WAIT cycles without an ack is
//   abandoned: the requester still gets its done pulse and zero data, and the
//   sticky timeout_err flag is set.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_req, if_addr                 fetch request, held until if_done
//   if_rdata, if_done               fetched word (registered), completion pulse
//   dm_req, dm_we, dm_addr, dm_wdata  load/store request, held until dm_done
//   dm_rdata, dm_done               load data (registered), completion pulse
//   mem_req, mem_we, mem_addr, mem_wdata  registered memory request
//   mem_rdata, mem_ack              memory read data and completion
//   stall                           global pipeline stall (combinational)
//   timeout_err                     sticky, set by any timed-out access
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_DM,
        BUSY_IF
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             at_limit;

    // The edge that would bring the counter up to MAX_WAIT is the timeout edge,
    // so mem_req is high for at most MAX_WAIT cycles. An ack on that same edge
    // still wins.
    assign at_limit = (wait_cnt == CNT_W'(MAX_WAIT - 1));

    // The done cycle releases the stall; that is the pipeline-advance edge.
    assign stall = (if_req & ~if_done) | (dm_req & ~dm_done);

    // NOTE: every register here is written with <= so all of them update
    // together from values sampled at the same edge; blocking = would let
    // later statements see already-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_done     <= 1'b0;
            dm_done     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;

            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (dm_req) begin
                        state     <= BUSY_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        state    <= BUSY_IF;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end

                BUSY_DM, BUSY_IF: begin
                    if (mem_ack || at_limit) begin
                        // Completion by ack or by timeout: same exit path,
                        // only the returned data differs.
                        state    <= IDLE;
                        wait_cnt <= '0;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        if (!mem_ack) begin
                            timeout_err <= 1'b1;
                        end
                        if (state == BUSY_IF) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            dm_done <= 1'b1;
                            if (!mem_ack) begin
                                dm_rdata <= '0;
                            end else if (!mem_we) begin
                                // Stores leave the last load data in place.
                                dm_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared single-port, variable-latency memory between instruction fetch (IF) and the MEM stage (load/store). Runs a req/ack handshake toward memory, returns data and a one-cycle done pulse to each requester, and drives the global pipeline stall. Every pipeline register, including MEM/WB, holds its value while the stall is high. Sits between the IF/MEM stages and the unified memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 15, maximum cycles mem_req stays high without mem_ack before timeout (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, registered
if_done  out  1  one-cycle pulse, fetch complete
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_done
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, registered
dm_done  out  1  one-cycle pulse, data access complete
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
mem_ack  in  1  memory completion, sampled on clk
stall  out  1  combinational: (if_req & ~if_done) | (dm_req & ~dm_done)
timeout_err  out  1  sticky: a transaction timed out

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction): FSM=IDLE; mem_req, mem_we, if_done, dm_done, timeout_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata, wait counter = 0. A pending memory access is abandoned; memory must tolerate mem_req dropping without ack.
- States: IDLE, BUSY_DM, BUSY_IF.
- IDLE: if dm_req=1 -> BUSY_DM. Latch dm_addr/dm_we/dm_wdata onto mem_*, set mem_req=1. Otherwise, if if_req=1 -> BUSY_IF. Latch if_addr, set mem_we=0, mem_req=1. Fixed priority DM > IF, because the MEM-stage instruction is older. IF cannot starve: dm_req only changes when the pipeline advances.
- BUSY_x: mem_req, mem_we, mem_addr and mem_wdata stay stable. Changes on the requester inputs are ignored.
  - On the edge where mem_ack=1: capture mem_rdata into if_rdata (BUSY_IF) or dm_rdata (BUSY_DM, loads only; stores leave dm_rdata unchanged). Drive mem_req=0, assert the matching done for exactly the next cycle, return to IDLE, clear the wait counter.
  - mem_ack while in IDLE is ignored.
- Latency: request seen in IDLE at edge N -> mem_req high after edge N. Ack sampled at edge N+k (k>=1) -> done high for the cycle after edge N+k. Minimum request-to-done is 2 cycles.
- The done cycle drops stall. That edge is the pipeline-advance edge. The arbiter is back in IDLE and treats the req seen at the next edge as a new transaction, so back-to-back accesses are legal.
- Wait counter increments each BUSY cycle without ack.
  - Counter reaching MAX_WAIT with no ack on that edge is a timeout: mem_req=0, done pulses, the target rdata register is loaded with 0, timeout_err=1, FSM -> IDLE.
  - timeout_err is cleared only by reset.
  - Ack on the same edge as the limit counts as success.
- Both reqs high in IDLE: serve DM, then IF on the first IDLE edge after dm_done if if_req is still high.
- mem_we=0 whenever mem_req=0 or the state is BUSY_IF.

Test Plan:
- Reset mid-BUSY_DM (rst_n low during a wait) -> mem_req=0, stall follows inputs, all outputs 0 in the same cycle, no done pulse.
- Single load: dm_req=1, dm_we=0, dm_addr=0x100, mem_ack after 3 cycles with mem_rdata=0xCAFEF00D -> mem_addr=0x100, mem_we=0; dm_rdata=0xCAFEF00D; dm_done a 1-cycle pulse; stall high exactly until the done cycle.
- Simultaneous requests: if_addr=0x40, dm store to 0x200 with wdata=0x12345678, both raised at the same edge -> memory sees the 0x200 write first, then a 0x40 read. Order: dm_done, then if_done. dm_rdata unchanged.
- Back-to-back fetches 0x0, 0x4, 0x8, ack 1 cycle after each mem_req -> three if_done pulses, each 2 cycles after the request is seen, with no idle gap beyond one cycle.
- Timeout: MAX_WAIT=15, mem_ack held 0 -> mem_req drops after 15 wait cycles; dm_done pulses; dm_rdata=0; timeout_err=1 and stays 1 through later successful accesses.
- Ack on the 15th cycle exactly -> success, data captured, timeout_err stays 0.
